// File: rtl/iram_fetch_pkg.sv
// -----------------------------------------------------------------------------
// iram_fetch_pkg
//   Shared definitions for the instruction memory block:
//     - default address/instruction widths, default depth, default NOP word
//     - controller state enum (CLEAR fills memory, RUN serves traffic)
//     - even-parity helper used when IRAM_PARITY_EN is defined
// -----------------------------------------------------------------------------
package iram_fetch_pkg;

    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_INSTR_WIDTH = 33;
    localparam int DEF_DEPTH       = 64;

    localparam logic [DEF_INSTR_WIDTH-1:0] DEF_NOP_WORD = '0;

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int PARITY_MAX_W = 256;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } iram_state_e;

    // Even parity: returns the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/iram_fetch_mem.sv
// -----------------------------------------------------------------------------
// iram_fetch_mem
//   Storage array: one synchronous write port, one synchronous read port with
//   an enable. The read register only updates when re is high, so a held
//   response never tracks later writes. A write and read to the same index in
//   the same cycle returns the new data (write-first).
//
//   Ports:
//     clk, rst_n    clock, async active-low reset (read register only)
//     we/waddr/wdata  write port
//     re/raddr        read port (enable, index)
//     rdata           registered read data, resets to zero
// -----------------------------------------------------------------------------
module iram_fetch_mem #(
    parameter int DATA_WIDTH = 33,
    parameter int DEPTH      = 64,
    parameter int IDX_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Contents are deliberately not reset; the controller's clear sweep
    // initialises every word.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/iram_fetch.sv
// -----------------------------------------------------------------------------
// iram_fetch
//   Instruction memory with a fetch port (valid/ready, 1-cycle registered
//   response, consumer hold) and a run-time load port. After reset a clear
//   sweep writes NOP_WORD into every word; no traffic is accepted until it
//   finishes (init_done). Addresses >= DEPTH never alias: fetches return
//   NOP_WORD with fetch_fault, loads are dropped with a load_err pulse.
//
//   Optional build macro IRAM_PARITY_EN: each word stores an even-parity bit
//   and the added output parity_err flags a recomputed mismatch on a response.
//
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     fetch_req, fetch_addr      fetch request
//     fetch_ready                fetch accepted when fetch_req && fetch_ready
//     fetch_valid, fetch_instr,
//     fetch_fault                registered response
//     fetch_hold                 consumer stall, freezes a valid response
//     load_valid, load_addr,
//     load_data, load_ready      load write request
//     load_err                   one-cycle pulse for a dropped out-of-range load
//     init_done                  clear sweep complete
//     parity_err (IRAM_PARITY_EN only)
//
//   Handshake: a request transfers on a rising clk edge where its valid
//   (fetch_req / load_valid) and ready are both high. Ready is a function of
//   registered state only, never of the matching valid. A fetch response is
//   presented while fetch_valid is high; it is consumed on any cycle where
//   fetch_hold is low, and frozen while fetch_hold is high.
// -----------------------------------------------------------------------------
module iram_fetch
    import iram_fetch_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int                     INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int                     DEPTH       = DEF_DEPTH,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = INSTR_WIDTH'(DEF_NOP_WORD)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_req,
    input  logic [ADDR_WIDTH-1:0]  fetch_addr,
    output logic                   fetch_ready,
    output logic                   fetch_valid,
    input  logic                   fetch_hold,
    output logic [INSTR_WIDTH-1:0] fetch_instr,
    output logic                   fetch_fault,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [ADDR_WIDTH-1:0]  load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    output logic                   load_err,
    output logic                   init_done
`ifdef IRAM_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IRAM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int MEM_W = INSTR_WIDTH + PAR_W;

    // Range limit one bit wider than the address so DEPTH == 2**ADDR_WIDTH fits.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    iram_state_e             state_q, state_d;
    logic [IDX_W-1:0]        clr_ptr_q, clr_ptr_d;

    logic                    fetch_acc, fetch_in_range;
    logic                    load_acc, load_in_range;
    logic                    valid_q, fault_q, load_err_q;

    logic                    mem_we;
    logic [IDX_W-1:0]        mem_waddr;
    logic [INSTR_WIDTH-1:0]  wr_word;
    logic [MEM_W-1:0]        mem_wdata;
    logic [MEM_W-1:0]        mem_rdata;

    assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_LIM);
    assign load_in_range  = ({1'b0, load_addr}  < DEPTH_LIM);

    assign fetch_ready = (state_q == RUN) && !(valid_q && fetch_hold);
    assign load_ready  = (state_q == RUN);
    assign init_done   = (state_q == RUN);

    assign fetch_acc = fetch_req && fetch_ready;
    assign load_acc  = load_valid && load_ready;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next state plus the single memory write port: the clear sweep owns it in
    // CLEAR, in-range loads own it in RUN.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        mem_we    = 1'b0;
        mem_waddr = clr_ptr_q;
        wr_word   = NOP_WORD;
        case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d = RUN;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            RUN: begin
                if (load_acc && load_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = load_addr[IDX_W-1:0];
                    wr_word   = load_data;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

`ifdef IRAM_PARITY_EN
    assign mem_wdata = {even_parity(PARITY_MAX_W'(wr_word)), wr_word};
`else
    assign mem_wdata = wr_word;
`endif

    iram_fetch_mem #(
        .DATA_WIDTH (MEM_W),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (fetch_acc && fetch_in_range),
        .raddr (fetch_addr[IDX_W-1:0]),
        .rdata (mem_rdata)
    );

    // ------------------------------------------------------- response state
    // The read register holds the data; fault_q selects the NOP substitute.
    // Both only change on an accept, so hold and idle keep the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            valid_q    <= fetch_acc || (valid_q && fetch_hold);
            load_err_q <= load_acc && !load_in_range;
            if (fetch_acc) begin
                fault_q <= !fetch_in_range;
            end
        end
    end

    assign fetch_valid = valid_q;
    assign fetch_fault = fault_q;
    assign fetch_instr = fault_q ? NOP_WORD : mem_rdata[INSTR_WIDTH-1:0];
    assign load_err    = load_err_q;

`ifdef IRAM_PARITY_EN
    // Stored word is {parity, data}; a clean word reduces to zero.
    assign parity_err = valid_q && !fault_q &&
                        (even_parity(PARITY_MAX_W'(mem_rdata)) != 1'b0);
`endif

endmodule

// File: tb/tb_iram_fetch.sv
// -----------------------------------------------------------------------------
// tb_iram_fetch
//   Directed steps followed by a randomized phase, checked against a word-array
//   model of the memory plus a queue of expected responses.
// -----------------------------------------------------------------------------
module tb_iram_fetch;

    localparam int AW = 8;
    localparam int IW = 33;
`ifdef IRAM_PARITY_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 64;
`endif
    localparam logic [IW-1:0] NOP = '0;

    // ------------------------------------------------------ clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          fetch_req, fetch_ready, fetch_valid, fetch_hold, fetch_fault;
    logic [AW-1:0] fetch_addr, load_addr;
    logic [IW-1:0] fetch_instr, load_data;
    logic          load_valid, load_ready, load_err, init_done;
`ifdef IRAM_PARITY_EN
    logic          parity_err;
`endif

    iram_fetch #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .DEPTH       (DEPTH),
        .NOP_WORD    (NOP)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_hold  (fetch_hold),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_err    (load_err),
        .init_done   (init_done)
`ifdef IRAM_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    // ------------------------------------------------------ reference model
    logic [IW-1:0] model_mem [DEPTH];
    logic          model_flip [DEPTH];   // stored parity bit deliberately corrupted
    logic [IW+1:0] exp_q [$];            // {parity_err, fault, instr}
    logic [IW+1:0] cur_resp;
    logic          m_valid;
    int            clr_cnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        clr_cnt  = 0;
        m_valid  = 1'b0;
        cur_resp = '0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]  = NOP;
            model_flip[i] = 1'b0;
        end
    endtask

    // ------------------------------------------------------ driver tasks
    task automatic drive(input logic req, input int faddr, input logic hold,
                         input logic lv, input int laddr, input logic [IW-1:0] ldata);
        fetch_req  = req;
        fetch_addr = AW'(faddr);
        fetch_hold = hold;
        load_valid = lv;
        load_addr  = AW'(laddr);
        load_data  = ldata;
    endtask

    // One clock with the currently driven inputs; predicts and checks outputs.
    task automatic cycle();
        logic running, rdy, acc, lacc, exp_lerr;
        logic [IW+1:0] e;
        int fa, la;
        #1;
        running = (clr_cnt >= DEPTH);
        rdy     = running && !(m_valid && fetch_hold);
        fa      = int'(fetch_addr);
        la      = int'(load_addr);
        check("fetch_ready", fetch_ready, rdy);
        acc      = fetch_req && rdy;
        lacc     = load_valid && running;
        exp_lerr = lacc && (la >= DEPTH);
        if (acc) begin
            if (fa >= DEPTH)
                e = {1'b0, 1'b1, NOP};
            else if (lacc && la == fa)
                e = {1'b0, 1'b0, load_data};
            else
                e = {model_flip[fa], 1'b0, model_mem[fa]};
            exp_q.push_back(e);
        end
        if (lacc && la < DEPTH) begin
            model_mem[la]  = load_data;
            model_flip[la] = 1'b0;
        end
        m_valid = acc || (m_valid && fetch_hold);
        @(posedge clk);
        #1;
        if (!running) clr_cnt++;
        check("fetch_valid", fetch_valid, m_valid);
        check("load_err", load_err, exp_lerr);
        check("init_done", init_done, clr_cnt >= DEPTH);
        check("load_ready", load_ready, clr_cnt >= DEPTH);
        if (acc) cur_resp = exp_q.pop_front();
        check("fetch_instr", fetch_instr, cur_resp[IW-1:0]);
        if (m_valid) begin
            check("fetch_fault", fetch_fault, cur_resp[IW]);
`ifdef IRAM_PARITY_EN
            check("parity_err", parity_err, cur_resp[IW+1]);
`endif
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, fetch_valid, 1'b0);
        check({tag, "_instr"}, fetch_instr, NOP);
        check({tag, "_fault"}, fetch_fault, 1'b0);
        check({tag, "_fready"}, fetch_ready, 1'b0);
        check({tag, "_lready"}, load_ready, 1'b0);
        check({tag, "_lerr"}, load_err, 1'b0);
        check({tag, "_init"}, init_done, 1'b0);
`ifdef IRAM_PARITY_EN
        check({tag, "_perr"}, parity_err, 1'b0);
`endif
    endtask

    // Asserts reset mid-cycle (away from the edge), checks outputs at once,
    // then releases it between edges.
    task automatic async_reset(input string tag);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Runs the clear sweep with a pending fetch of 0, then takes its response.
    task automatic clear_then_fetch0(input string tag);
        drive(1'b1, 0, 1'b0, 1'b0, 0, '0);
        repeat (DEPTH) cycle();
        check({tag, "_init_done"}, init_done, 1'b1);
        cycle();
        check({tag, "_first_instr"}, fetch_instr, NOP);
        check({tag, "_first_fault"}, fetch_fault, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0, 0, '0);
        cycle();
    endtask

    // ------------------------------------------------------ stimulus
    initial begin
        logic [IW-1:0] rd;
        int ra;
        drive(1'b0, 0, 1'b0, 1'b0, 0, '0);
        model_reset();
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Clear sweep, then first fetch returns NOP.
        clear_then_fetch0("boot");

        // Loads then back-to-back fetches.
        drive(1'b0, 0, 1'b0, 1'b1, 5, 33'h0_1200_0020); cycle();
        drive(1'b0, 0, 1'b0, 1'b1, 6, 33'h0_5221_0000); cycle();
        drive(1'b1, 5, 1'b0, 1'b0, 0, '0); cycle();
        check("b2b_instr5", fetch_instr, 33'h0_1200_0020);
        drive(1'b1, 6, 1'b0, 1'b0, 0, '0); cycle();
        check("b2b_instr6", fetch_instr, 33'h0_5221_0000);
        drive(1'b0, 0, 1'b0, 1'b0, 0, '0); cycle();

        // Held response is not affected by a load to the same address.
        drive(1'b1, 5, 1'b0, 1'b0, 0, '0); cycle();
        drive(1'b1, 5, 1'b1, 1'b1, 5, 33'h1);
        repeat (3) cycle();
        check("hold_instr", fetch_instr, 33'h0_1200_0020);
        check("hold_valid", fetch_valid, 1'b1);
        drive(1'b1, 5, 1'b0, 1'b0, 0, '0); cycle();
        check("after_hold_instr", fetch_instr, 33'h1);
        drive(1'b0, 0, 1'b0, 1'b0, 0, '0); cycle();

        // Write-first, fetch fault, load error without aliasing.
        drive(1'b1, 9, 1'b0, 1'b1, 9, 33'hA); cycle();
        check("wfirst_instr", fetch_instr, 33'hA);
        drive(1'b1, 70, 1'b0, 1'b0, 0, '0); cycle();
        check("oob_fault", fetch_fault, 1'b1);
        check("oob_instr", fetch_instr, NOP);
        drive(1'b0, 0, 1'b0, 1'b1, 64, 33'h1_2345_6789); cycle();
        check("lerr_pulse", load_err, 1'b1);
        drive(1'b1, 0, 1'b0, 1'b0, 0, '0); cycle();
        check("lerr_gone", load_err, 1'b0);
        check("no_alias_instr", fetch_instr, NOP);
        drive(1'b0, 0, 1'b0, 1'b0, 0, '0); cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ra = int'($urandom_range(0, DEPTH + 8));
            rd = IW'({$urandom, $urandom});
            drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, DEPTH + 8)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ra, rd);
            if ($urandom_range(0, 3) == 0) fetch_addr = AW'(ra);
            cycle();
        end
        drive(1'b0, 0, 1'b0, 1'b0, 0, '0); cycle();

        // Reset during a held response.
        drive(1'b1, 9, 1'b0, 1'b0, 0, '0); cycle();
        drive(1'b0, 0, 1'b1, 1'b0, 0, '0); cycle();
        async_reset("rst_hold");
        clear_then_fetch0("reclear1");

        // Reset in the middle of the clear sweep.
        async_reset("rst_pre");
        drive(1'b1, 0, 1'b0, 1'b0, 0, '0);
        repeat (20) cycle();
        async_reset("rst_clear");
        clear_then_fetch0("reclear2");

`ifdef IRAM_PARITY_EN
        // Corrupt the stored parity bit of word 3 only.
        drive(1'b0, 0, 1'b0, 1'b1, 3, 33'h1_0000_0003); cycle();
        drive(1'b0, 0, 1'b0, 1'b1, 4, 33'h0_0000_0004); cycle();
        drive(1'b0, 0, 1'b0, 1'b0, 0, '0); cycle();
        u_dut.u_mem.mem[3][IW] = ~u_dut.u_mem.mem[3][IW];
        model_flip[3] = 1'b1;
        drive(1'b1, 3, 1'b0, 1'b0, 0, '0); cycle();
        check("par_bad", parity_err, 1'b1);
        drive(1'b1, 4, 1'b0, 1'b0, 0, '0); cycle();
        check("par_good", parity_err, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0, 0, '0); cycle();
`endif

        // ------------------------------------------------------ report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iram_fetch.md
Name: iram_fetch

Overview:
- Parametrised instruction memory with two ports: a fetch port (valid/ready handshake, registered output) toward the CPU front end, and a load port for writing programs at run time.
- After reset, an internal clear sequencer fills memory with a NOP word before any traffic is accepted.
- Out-of-range accesses are flagged; they never alias.
- Replaces the single-port, bidirectional-bus, no-reset instruction RAM.

Parameters:
- ADDR_WIDTH, 8, width of fetch and load addresses.
- INSTR_WIDTH, 33, instruction word width.
- DEPTH, 64, number of words; need not be a power of two; must be ≤ 2**ADDR_WIDTH.
- NOP_WORD, {INSTR_WIDTH{1'b0}}, word used for clear fill and for fault responses.

Ports:
- clk  in  1  Single clock; all state on posedge.
- rst_n  in  1  Asynchronous, active-low reset.
- fetch_req  in  1  Fetch request valid.
- fetch_addr  in  ADDR_WIDTH  Fetch word address.
- fetch_ready  out  1  Fetch request accepted this cycle when fetch_req && fetch_ready.
- fetch_valid  out  1  fetch_instr holds a response.
- fetch_hold  in  1  Consumer stall; response must be held while asserted.
- fetch_instr  out  INSTR_WIDTH  Response instruction word.
- fetch_fault  out  1  Response address was ≥ DEPTH; qualified by fetch_valid.
- load_valid  in  1  Load write request.
- load_ready  out  1  Load write accepted when load_valid && load_ready.
- load_addr  in  ADDR_WIDTH  Load word address.
- load_data  in  INSTR_WIDTH  Load word.
- load_err  out  1  One-cycle pulse: accepted load addressed ≥ DEPTH; write dropped.
- init_done  out  1  High once the clear sequence has completed.

Behaviour:
- Reset (async assert, sync release) sets:
  - fetch_valid=0, fetch_instr=0, fetch_fault=0.
  - fetch_ready=0, load_ready=0, load_err=0, init_done=0.
  - state=CLEAR, clr_ptr=0.
- Memory contents are not reset directly; CLEAR overwrites them.
- State machine, two states:
  - CLEAR: one write per cycle, mem[clr_ptr] <= NOP_WORD, clr_ptr++. After the write of DEPTH-1, go to RUN. CLEAR lasts exactly DEPTH cycles after reset release.
  - RUN: terminal state. init_done=1 registered, first high in the first RUN cycle.
- fetch_ready = (state==RUN) && !(fetch_valid && fetch_hold). Combinational from state/regs only, never from fetch_req.
- Fetch acceptance at posedge N (fetch_req && fetch_ready):
  - At N+1: fetch_valid=1.
  - Address < DEPTH: fetch_instr=mem[fetch_addr], fetch_fault=0.
  - Otherwise: fetch_instr=NOP_WORD, fetch_fault=1.
  - Latency is 1 cycle; back-to-back accepts give one response per cycle.
- Hold and idle:
  - While fetch_valid && fetch_hold: fetch_instr, fetch_fault and fetch_valid are frozen and no new fetch is accepted.
  - No accept and no hold: fetch_valid falls to 0; fetch_instr keeps its last value.
- Load port:
  - load_ready = (state==RUN).
  - On accept with addr < DEPTH, write mem[load_addr] <= load_data.
  - On accept with addr ≥ DEPTH, no write; load_err=1 for the next cycle only.
- Same-cycle fetch and load to the same address is write-first: the fetch response carries load_data.
- Held response does not track memory: if a load rewrites the address of a held fetch, the held fetch_instr does not change.
- rst_n asserted mid-CLEAR or mid-RUN: all outputs return to reset values immediately. CLEAR restarts from 0 after release. An in-flight response is lost.
- clr_ptr width is $clog2(DEPTH); compare against DEPTH-1, no wrap.

Optional Feature:
- Macro: IRAM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit, computed on load writes and on CLEAR writes.
  - The parity bit of NOP_WORD is stored correctly.
  - On every fetch response, recompute parity. A mismatch drives added output port parity_err (1 bit, qualified by fetch_valid, held with the response).
  - Reset value of parity_err is 0.
- When undefined: no extra storage bit, no parity_err port, identical timing.

Decomposition:
- Shared package holds:
  - Default INSTR_WIDTH/ADDR_WIDTH constants and the NOP_WORD constant.
  - State enum {CLEAR, RUN}.
  - A parity function, used by the parity option.
- One natural sub-module: iram_fetch_mem, the storage array with one synchronous write port and one synchronous read port plus write-first bypass. Holds no handshake logic.
- The top level holds the FSM, clear pointer, handshakes and output register.

Test Plan (DEPTH=64 unless noted):
- Reset, then hold fetch_req=1 addr=0: fetch_ready=0 for 64 cycles; init_done rises on cycle 65; first response fetch_instr=NOP_WORD, fetch_fault=0.
- Load addr 5 = 33'h0_1200_0020 and addr 6 = 33'h0_5221_0000, then fetch 5, 6 back-to-back: responses in consecutive cycles with those values, each 1 cycle after accept.
- Fetch addr 5 with fetch_hold=1 for 3 cycles while loading addr 5 = 33'h1: fetch_valid stays 1, fetch_instr stays 33'h0_1200_0020, fetch_ready=0 for 3 cycles; the next fetch of 5 returns 33'h1.
- Same-cycle load addr 9 = 33'hA and fetch addr 9: response 33'hA. Fetch addr 70: fetch_fault=1, fetch_instr=NOP_WORD. Load addr 64: load_err pulses once, memory unchanged.
- Assert rst_n low mid-CLEAR (cycle 20) and mid-held-response: outputs zero immediately; the full 64-cycle CLEAR repeats.
- With IRAM_PARITY_EN, DEPTH=16: force-flip one stored bit of addr 3, fetch 3 -> parity_err=1 with the response; fetch 4 -> parity_err=0.
